wb_arbiter: RTL and testbench

// Writeback arbiter for the dual-issue core. Collects completed results from NUM_SRC functional units
// (ALU0, ALU1, LSU, MULDIV) and selects up to two per cycle, oldest first by age tag. Drives the

---
 rtl/wb_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks up to two eligible results per cycle, oldest age first,
// and drives the register file's two write ports one cycle later.
module wb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int AGE_W   = 4,
    parameter int REG_AW  = 6
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*REG_AW-1:0] src_waddr,
    input  logic [NUM_SRC*4-1:0]      src_we,
    input  logic [NUM_SRC*32-1:0]     src_wdata,
    input  logic [NUM_SRC*AGE_W-1:0]  src_age,
    output logic [3:0]                inst1_we,
    output logic [REG_AW-1:0]         inst1_waddr,
    output logic [31:0]               inst1_wdata,
    output logic [3:0]                inst2_we,
    output logic [REG_AW-1:0]         inst2_waddr,
    output logic [31:0]               inst2_wdata,
    output logic [31:0]               stall_cnt
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [REG_AW-1:0] addr_w [NUM_SRC];
    logic [3:0]        we_w   [NUM_SRC];
    logic [31:0]       data_w [NUM_SRC];
    logic [AGE_W-1:0]  age_w  [NUM_SRC];
    logic [NUM_SRC-1:0] elig, nul, gnt;

    logic             g1_vld, g2_vld;
    logic [IDX_W-1:0] g1_idx, g2_idx;
    logic             stall_d;

    logic [3:0]        inst1_we_q, inst1_we_d, inst2_we_q, inst2_we_d;
    logic [REG_AW-1:0] inst1_waddr_q, inst1_waddr_d, inst2_waddr_q, inst2_waddr_d;
    logic [31:0]       inst1_wdata_q, inst1_wdata_d, inst2_wdata_q, inst2_wdata_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    // Modulo age compare: a is strictly older than b when (a-b) wraps negative.
    function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] diff;
        diff = a - b;
        return diff[AGE_W-1];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            addr_w[i] = src_waddr[i*REG_AW +: REG_AW];
            we_w[i]   = src_we[i*4 +: 4];
            data_w[i] = src_wdata[i*32 +: 32];
            age_w[i]  = src_age[i*AGE_W +: AGE_W];
            nul[i]    = src_valid[i] && ((we_w[i] == 4'd0) || (addr_w[i] == '0));
            elig[i]   = src_valid[i] && (we_w[i] != 4'd0) && (addr_w[i] != '0);
        end
    end

    // Ascending scan with strict compare: equal ages keep the lower index.
    always_comb begin
        g1_vld = 1'b0;
        g1_idx = '0;
        g2_vld = 1'b0;
        g2_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i] && (!g1_vld || older(age_w[i], age_w[g1_idx]))) begin
                g1_vld = 1'b1;
                g1_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (g1_vld && elig[i] && (IDX_W'(i) != g1_idx) && (addr_w[i] != addr_w[g1_idx]) &&
                (!g2_vld || older(age_w[i], age_w[g2_idx]))) begin
                g2_vld = 1'b1;
                g2_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            gnt[i] = (g1_vld && (g1_idx == IDX_W'(i))) || (g2_vld && (g2_idx == IDX_W'(i)));
        end
        src_ready = resetn ? (gnt | nul) : '0;
        stall_d   = |(src_valid & ~(gnt | nul));
    end

    always_comb begin
        inst1_we_d    = 4'd0;
        inst1_waddr_d = inst1_waddr_q;
        inst1_wdata_d = inst1_wdata_q;
        inst2_we_d    = 4'd0;
        inst2_waddr_d = inst2_waddr_q;
        inst2_wdata_d = inst2_wdata_q;
        stall_cnt_d   = stall_cnt_q + {31'd0, stall_d};
        if (g1_vld) begin
            inst1_we_d    = we_w[g1_idx];
            inst1_waddr_d = addr_w[g1_idx];
            inst1_wdata_d = data_w[g1_idx];
        end
        if (g2_vld) begin
            inst2_we_d    = we_w[g2_idx];
            inst2_waddr_d = addr_w[g2_idx];
            inst2_wdata_d = data_w[g2_idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst1_we_q    <= 4'd0;
            inst1_waddr_q <= '0;
            inst1_wdata_q <= 32'd0;
            inst2_we_q    <= 4'd0;
            inst2_waddr_q <= '0;
            inst2_wdata_q <= 32'd0;
            stall_cnt_q   <= 32'd0;
        end else begin
            inst1_we_q    <= inst1_we_d;
            inst1_waddr_q <= inst1_waddr_d;
            inst1_wdata_q <= inst1_wdata_d;
            inst2_we_q    <= inst2_we_d;
            inst2_waddr_q <= inst2_waddr_d;
            inst2_wdata_q <= inst2_wdata_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign inst1_we    = inst1_we_q;
    assign inst1_waddr = inst1_waddr_q;
    assign inst1_wdata = inst1_wdata_q;
    assign inst2_we    = inst2_we_q;
    assign inst2_waddr = inst2_waddr_q;
    assign inst2_wdata = inst2_wdata_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;

    logic         clk = 1'b0;
    logic         resetn;
    logic [3:0]   src_valid;
    logic [3:0]   src_ready;
    logic [23:0]  src_waddr;
    logic [15:0]  src_we;
    logic [127:0] src_wdata;
    logic [15:0]  src_age;
    logic [3:0]   inst1_we, inst2_we;
    logic [5:0]   inst1_waddr, inst2_waddr;
    logic [31:0]  inst1_wdata, inst2_wdata;
    logic [31:0]  stall_cnt;

    int n_checks = 0;
    int n_errs   = 0;

    wb_arbiter #(.NUM_SRC(4), .AGE_W(4), .REG_AW(6)) dut (
        .clk(clk), .resetn(resetn),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_waddr(src_waddr), .src_we(src_we), .src_wdata(src_wdata), .src_age(src_age),
        .inst1_we(inst1_we), .inst1_waddr(inst1_waddr), .inst1_wdata(inst1_wdata),
        .inst2_we(inst2_we), .inst2_waddr(inst2_waddr), .inst2_wdata(inst2_wdata),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [3:0] age, input logic [5:0] addr,
                           input logic [3:0] we, input logic [31:0] data);
        src_valid[i]         = 1'b1;
        src_age[i*4 +: 4]    = age;
        src_waddr[i*6 +: 6]  = addr;
        src_we[i*4 +: 4]     = we;
        src_wdata[i*32 +: 32] = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port1(input string tag, input logic [3:0] we, input logic [5:0] a, input logic [31:0] d);
        check_eq({tag, ".we1"},   32'(inst1_we),    32'(we));
        check_eq({tag, ".addr1"}, 32'(inst1_waddr), 32'(a));
        check_eq({tag, ".data1"}, inst1_wdata,      d);
    endtask

    task automatic chk_port2(input string tag, input logic [3:0] we, input logic [5:0] a, input logic [31:0] d);
        check_eq({tag, ".we2"},   32'(inst2_we),    32'(we));
        check_eq({tag, ".addr2"}, 32'(inst2_waddr), 32'(a));
        check_eq({tag, ".data2"}, inst2_wdata,      d);
    endtask

    initial begin
        resetn    = 1'b0;
        src_valid = '0;
        src_waddr = '0;
        src_we    = '0;
        src_wdata = '0;
        src_age   = '0;
        for (int i = 0; i < 4; i++) set_src(i, 4'd0, 6'(i + 1), 4'hF, 32'(i));
        #2;
        // reset with all sources valid
        check_eq("rst.ready", 32'(src_ready), 32'h0);
        check_eq("rst.we1", 32'(inst1_we), 32'h0);
        check_eq("rst.we2", 32'(inst2_we), 32'h0);
        check_eq("rst.stall", stall_cnt, 32'd0);
        repeat (3) step();
        check_eq("rst.ready_hold", 32'(src_ready), 32'h0);
        check_eq("rst.stall_hold", stall_cnt, 32'd0);
        check_eq("rst.addr1", 32'(inst1_waddr), 32'h0);
        resetn = 1'b1;
        #1;
        check_eq("rel.ready", 32'(src_ready), 32'h3);
        step();
        chk_port1("rel", 4'hF, 6'd1, 32'd0);
        chk_port2("rel", 4'hF, 6'd2, 32'd1);
        check_eq("rel.stall", stall_cnt, 32'd1);
        src_valid = '0;
        step();
        check_eq("idle.we1", 32'(inst1_we), 32'h0);
        check_eq("idle.we2", 32'(inst2_we), 32'h0);
        check_eq("idle.stall", stall_cnt, 32'd1);

        // two results, src2 older
        set_src(0, 4'd3, 6'd5, 4'hF, 32'hAAAA0000);
        set_src(2, 4'd1, 6'd7, 4'hF, 32'h12345678);
        #1;
        check_eq("two.ready", 32'(src_ready), 32'h5);
        step();
        chk_port1("two", 4'hF, 6'd7, 32'h12345678);
        chk_port2("two", 4'hF, 6'd5, 32'hAAAA0000);
        check_eq("two.stall", stall_cnt, 32'd1);
        src_valid = '0;

        // same destination: younger waits
        set_src(1, 4'd2, 6'd9, 4'hF, 32'h11111111);
        set_src(3, 4'd4, 6'd9, 4'hF, 32'h33333333);
        #1;
        check_eq("dst.ready1", 32'(src_ready), 32'h2);
        step();
        chk_port1("dst1", 4'hF, 6'd9, 32'h11111111);
        chk_port2("dst1", 4'h0, 6'd5, 32'hAAAA0000);
        check_eq("dst.stall", stall_cnt, 32'd2);
        src_valid[1] = 1'b0;
        #1;
        check_eq("dst.ready2", 32'(src_ready), 32'h8);
        step();
        chk_port1("dst2", 4'hF, 6'd9, 32'h33333333);
        check_eq("dst2.we2", 32'(inst2_we), 32'h0);
        src_valid = '0;

        // three compete, oldest two win
        set_src(0, 4'd2, 6'd10, 4'hF, 32'h000000A0);
        set_src(1, 4'd0, 6'd11, 4'hF, 32'h000000B1);
        set_src(2, 4'd1, 6'd12, 4'hF, 32'h000000C2);
        #1;
        check_eq("three.ready1", 32'(src_ready), 32'h6);
        step();
        chk_port1("three1", 4'hF, 6'd11, 32'h000000B1);
        chk_port2("three1", 4'hF, 6'd12, 32'h000000C2);
        check_eq("three.stall", stall_cnt, 32'd3);
        src_valid[1] = 1'b0;
        src_valid[2] = 1'b0;
        #1;
        check_eq("three.ready2", 32'(src_ready), 32'h1);
        step();
        chk_port1("three2", 4'hF, 6'd10, 32'h000000A0);
        check_eq("three2.we2", 32'(inst2_we), 32'h0);
        src_valid = '0;

        // age wraparound: 15 is older than 1
        set_src(0, 4'd15, 6'd13, 4'hF, 32'hF0F0F0F0);
        set_src(1, 4'd1, 6'd14, 4'hF, 32'h01010101);
        #1;
        check_eq("wrap.ready", 32'(src_ready), 32'h3);
        step();
        chk_port1("wrap", 4'hF, 6'd13, 32'hF0F0F0F0);
        chk_port2("wrap", 4'hF, 6'd14, 32'h01010101);
        src_valid = '0;

        // null write plus partial byte enables
        set_src(0, 4'd0, 6'd0, 4'hF, 32'h99999999);
        set_src(1, 4'd0, 6'd3, 4'b0011, 32'hDEADBEEF);
        #1;
        check_eq("null.ready", 32'(src_ready), 32'h3);
        step();
        chk_port1("null", 4'b0011, 6'd3, 32'hDEADBEEF);
        check_eq("null.we2", 32'(inst2_we), 32'h0);
        check_eq("null.stall", stall_cnt, 32'd3);
        src_valid = '0;

        // asynchronous reset mid-operation drops the pending write
        set_src(2, 4'd0, 6'd20, 4'hF, 32'h55555555);
        step();
        check_eq("mid.we1_pre", 32'(inst1_we), 32'hF);
        resetn = 1'b0;
        #1;
        check_eq("mid.we1", 32'(inst1_we), 32'h0);
        check_eq("mid.data1", inst1_wdata, 32'h0);
        check_eq("mid.ready", 32'(src_ready), 32'h0);
        check_eq("mid.stall", stall_cnt, 32'd0);
        src_valid = '0;
        resetn = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
